block_placer: RTL

- Downstream consumer of the 3-piece block generator in the 8x8 block-puzzle game.
- Accepts a player placement request (piece select plus cursor), checks that the piece fits, commits it to the 64-bit board, then clears full rows and columns and updates the score.
- Tracks which of the three offered pieces are used, pulses generate_new to request a refill, and runs a sequential fit scan to detect game over.

---
 rtl/block_pkg.sv | 44 ++++
 rtl/block_placer_if.sv | 30 +++
 rtl/block_placer_shape_footprint.sv | 43 ++++
 rtl/block_placer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// ----------------------------------------------------------------------------
// block_pkg
// Shared definitions for the block-puzzle placer:
//   - FSM state encodings (state_t, ST_*)
//   - board and piece geometry (BOARD_DIM, MASK_DIM, MASK_W)
//   - popcount16, row_full and col_full helper functions
// ----------------------------------------------------------------------------
package block_pkg;

    localparam int BOARD_DIM = 8;
    localparam int MASK_DIM  = 4;
    localparam int MASK_W    = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CHECK   = 3'd1;
    localparam state_t ST_COMMIT  = 3'd2;
    localparam state_t ST_CLEAR   = 3'd3;
    localparam state_t ST_REFILL  = 3'd4;
    localparam state_t ST_WAITGEN = 3'd5;
    localparam state_t ST_SCAN    = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    // Board bit 8*row+col; a row is one contiguous byte.
    function automatic logic row_full(input logic [63:0] b, input int r);
        return &b[BOARD_DIM*r +: BOARD_DIM];
    endfunction

    function automatic logic col_full(input logic [63:0] b, input int c);
        logic f;
        f = 1'b1;
        for (int r = 0; r < BOARD_DIM; r++) f = f & b[BOARD_DIM*r + c];
        return f;
    endfunction

endpackage

// File: rtl/block_placer_if.sv
// ----------------------------------------------------------------------------
// block_placer_if
// Placement request/response channel of block_placer.
//   place_req        one-cycle request strobe
//   sel              piece index 0..2 (3 is illegal)
//   cur_row/cur_col  anchor of the 4x4 mask on the board
//   busy             placer is processing a request
//   place_ok         one-cycle pulse: placement fully processed
//   place_err        one-cycle pulse: request rejected
// Modports: master (requester), slave (block_placer).
// ----------------------------------------------------------------------------
interface block_placer_if;
    logic       place_req;
    logic [1:0] sel;
    logic [2:0] cur_row;
    logic [2:0] cur_col;
    logic       busy;
    logic       place_ok;
    logic       place_err;

    modport master (
        output place_req, sel, cur_row, cur_col,
        input  busy, place_ok, place_err
    );

    modport slave (
        input  place_req, sel, cur_row, cur_col,
        output busy, place_ok, place_err
    );
endinterface

// File: rtl/block_placer_shape_footprint.sv
// ----------------------------------------------------------------------------
// shape_footprint
// Combinational projection of a 4x4 piece mask onto the 8x8 board.
//   mask   piece mask; cell (r,c) is bit 15-(4r+c)
//   row    anchor row (top-left of the mask)
//   col    anchor column
//   fp     occupied board cells, bit 8*row+col
//   valid  0 when any set mask cell falls off the board
// ----------------------------------------------------------------------------
module shape_footprint
    import block_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    output logic [63:0]       fp,
    output logic              valid
);

    logic [3:0] rr;
    logic [3:0] cc;

    // NOTE: every variable written in always_comb gets a default first, so
    // no path leaves it holding its old value (which would infer a latch).
    always_comb begin
        fp    = '0;
        valid = 1'b1;
        rr    = '0;
        cc    = '0;
        for (int r = 0; r < MASK_DIM; r++) begin
            for (int c = 0; c < MASK_DIM; c++) begin
                // 4-bit sums: anything reaching 8 is off-board, never wrapped.
                rr = {1'b0, row} + 4'(r);
                cc = {1'b0, col} + 4'(c);
                if (mask[MASK_W-1-(MASK_DIM*r+c)]) begin
                    if (rr[3] || cc[3]) valid = 1'b0;
                    else                fp[{rr[2:0], cc[2:0]}] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/block_placer.sv
// ----------------------------------------------------------------------------
// block_placer
// Places one of three offered pieces on the 8x8 board, clears full rows and
// columns, scores, requests a refill once all three pieces are used, and scans
// the remaining pieces for any legal fit to detect game over.
//   clk, reset           clock; asynchronous active-high reset
//   block1..block3       offered pieces, mask in [15:0]; held stable while busy
//   ctrl (slave)         place_req/sel/cur_row/cur_col in; busy/place_ok/place_err out
//   board                occupancy, bit 8*row+col
//   used                 per-piece used flags
//   generate_new         one-cycle refill request
//   score                saturating score
//   game_over            sticky until reset
// Build option: define COMBO_BONUS_EN to score 2*SCORE_PER_LINE per line when
// a placement clears two or more lines.
// ----------------------------------------------------------------------------
module block_placer
    import block_pkg::*;
#(
    parameter int SCORE_W        = 16,
    parameter int SCORE_PER_LINE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        block1,
    input  logic [63:0]        block2,
    input  logic [63:0]        block3,
    block_placer_if.slave      ctrl,
    output logic [63:0]        board,
    output logic [2:0]         used,
    output logic               generate_new,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    state_t            state;
    logic [1:0]        sel_q;
    logic [2:0]        row_q, col_q;
    logic [MASK_W-1:0] mask_q;
    logic [1:0]        scan_piece;
    logic [5:0]        scan_pos;
    logic              wait_cnt;
    logic              place_ok_q, place_err_q;

    wire unused_block_bits = &{1'b0, block1[63:16], block2[63:16], block3[63:16]};

    // Index 3 is the illegal selector and always reads as an empty mask.
    logic [MASK_W-1:0] masks [4];
    assign masks[0] = block1[MASK_W-1:0];
    assign masks[1] = block2[MASK_W-1:0];
    assign masks[2] = block3[MASK_W-1:0];
    assign masks[3] = '0;

    logic [63:0] place_fp, scan_fp;
    logic        place_valid, scan_valid;

    shape_footprint u_place_fp (
        .mask (mask_q),
        .row  (row_q),
        .col  (col_q),
        .fp   (place_fp),
        .valid(place_valid)
    );

    shape_footprint u_scan_fp (
        .mask (masks[scan_piece]),
        .row  (scan_pos[5:3]),
        .col  (scan_pos[2:0]),
        .fp   (scan_fp),
        .valid(scan_valid)
    );

    logic [3:0] used_ext;
    logic       reject, scan_fit;
    assign used_ext = {1'b0, used};
    assign reject   = (sel_q == 2'd3) || used_ext[sel_q] || (mask_q == '0)
                    || !place_valid || ((place_fp & board) != '0);
    assign scan_fit = scan_valid && (masks[scan_piece] != '0)
                    && ((scan_fp & board) == '0);

    // Full-line detection on the committed board, and the lowest unused
    // pieces for starting and continuing the fit scan.
    logic [7:0]   full_rows, full_cols;
    logic [63:0]  clear_mask;
    logic [4:0]   lines;
    logic [1:0]   first_unused, next_piece;
    logic         next_found;
    logic [SCORE_W:0] line_pts;
    int           per_line;

    always_comb begin
        full_rows    = '0;
        full_cols    = '0;
        clear_mask   = '0;
        first_unused = 2'd0;
        next_piece   = scan_piece;
        next_found   = 1'b0;
        for (int i = 0; i < BOARD_DIM; i++) begin
            full_rows[i] = row_full(board, i);
            full_cols[i] = col_full(board, i);
        end
        for (int r = 0; r < BOARD_DIM; r++)
            for (int c = 0; c < BOARD_DIM; c++)
                clear_mask[BOARD_DIM*r+c] = full_rows[r] | full_cols[c];
        lines = popcount16({full_rows, full_cols});
        per_line = SCORE_PER_LINE;
`ifdef COMBO_BONUS_EN
        if (lines >= 5'd2) per_line = 2 * SCORE_PER_LINE;
`else
        per_line = SCORE_PER_LINE;
`endif
        line_pts = (SCORE_W+1)'(per_line * int'(lines));
        // Descending loops so the lowest qualifying index wins.
        for (int k = 2; k >= 0; k--) begin
            if (!used[k]) first_unused = 2'(k);
            if (k > int'(scan_piece) && !used[k]) begin
                next_found = 1'b1;
                next_piece = 2'(k);
            end
        end
    end

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W:0]   b);
        logic [SCORE_W+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s[SCORE_W+1:SCORE_W] != 2'b00) ? '1 : s[SCORE_W-1:0];
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sel_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            mask_q       <= '0;
            scan_piece   <= '0;
            scan_pos     <= '0;
            wait_cnt     <= 1'b0;
            board        <= '0;
            used         <= '0;
            score        <= '0;
            game_over    <= 1'b0;
            generate_new <= 1'b0;
            place_ok_q   <= 1'b0;
            place_err_q  <= 1'b0;
        end else begin
            generate_new <= 1'b0;
            place_ok_q   <= 1'b0;
            place_err_q  <= 1'b0;
            case (state)
                ST_IDLE: if (ctrl.place_req && !game_over) begin
                    sel_q  <= ctrl.sel;
                    row_q  <= ctrl.cur_row;
                    col_q  <= ctrl.cur_col;
                    mask_q <= masks[ctrl.sel];
                    state  <= ST_CHECK;
                end
                ST_CHECK: begin
                    place_err_q <= reject;
                    state       <= reject ? ST_IDLE : ST_COMMIT;
                end
                ST_COMMIT: begin
                    board        <= board | place_fp;
                    used[sel_q]  <= 1'b1;
                    score        <= sat_add(score, (SCORE_W+1)'(popcount16(mask_q)));
                    state        <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    board <= board & ~clear_mask;
                    score <= sat_add(score, line_pts);
                    state <= ST_REFILL;
                end
                ST_REFILL: begin
                    scan_pos <= '0;
                    if (used == 3'b111) begin
                        generate_new <= 1'b1;
                        used         <= '0;
                        scan_piece   <= 2'd0;
                        wait_cnt     <= 1'b1;
                        state        <= ST_WAITGEN;
                    end else begin
                        scan_piece <= first_unused;
                        state      <= ST_SCAN;
                    end
                end
                ST_WAITGEN: begin
                    if (!wait_cnt) state <= ST_SCAN;
                    wait_cnt <= 1'b0;
                end
                ST_SCAN: begin
                    if (scan_fit) begin
                        state <= ST_DONE;
                    end else if (scan_pos == 6'd63) begin
                        if (next_found) begin
                            scan_piece <= next_piece;
                            scan_pos   <= '0;
                        end else begin
                            game_over <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else begin
                        scan_pos <= scan_pos + 6'd1;
                    end
                end
                ST_DONE: begin
                    place_ok_q <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ctrl.busy      = (state != ST_IDLE);
    assign ctrl.place_ok  = place_ok_q;
    assign ctrl.place_err = place_err_q;

endmodule
